// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe
// Pipelined signed adder tree that reduces NUM_IN operands per beat to one sum,
// followed by a saturating packet accumulator with a registered result stage.
// An input capture stage plus clog2(NUM_IN) adder levels feed the accumulator,
// giving clog2(NUM_IN)+1 cycles from an accepted last beat to out_valid.
// The whole pipeline stalls as one unit whenever a pending result is not taken.

module adder_tree_pipe #(
    parameter int FEATURE_WIDTH = 16,
    parameter int NUM_IN        = 9,
    parameter int OUT_WIDTH     = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                            fast_clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_IN*FEATURE_WIDTH-1:0] in_data,
    input  logic                            in_acc,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OUT_WIDTH-1:0]     out_data,
    output logic                            out_sat,
    output logic [CNT_WIDTH-1:0]            out_beats
);

    localparam int LVLS = $clog2(NUM_IN);

    // Number of live nodes at tree level k (level 0 is the captured operand row).
    function automatic int lvl_cnt(input int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    // Start index of tree level k inside the flat node array.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o += lvl_cnt(i);
        end
        return o;
    endfunction

    localparam int NODES = lvl_off(LVLS + 1);
    localparam int TAIL  = lvl_off(LVLS);

    localparam logic signed [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]        CNT_ONE = CNT_WIDTH'(1);

    // Widen one operand to the tree width; OUT_WIDTH covers all growth, so the
    // tree itself can never overflow.
    function automatic logic signed [OUT_WIDTH-1:0] sext(input logic [FEATURE_WIDTH-1:0] v);
        return {{(OUT_WIDTH-FEATURE_WIDTH){v[FEATURE_WIDTH-1]}}, v};
    endfunction

    // Signed add clamped to the OUT_WIDTH range; MSB of the result flags a clamp.
    function automatic logic [OUT_WIDTH:0] sat_add(input logic signed [OUT_WIDTH-1:0] a,
                                                   input logic signed [OUT_WIDTH-1:0] b);
        logic [OUT_WIDTH:0] s;
        s = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
        if (s[OUT_WIDTH] != s[OUT_WIDTH-1]) begin
            return {1'b1, (s[OUT_WIDTH] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    // Tree node storage, all levels packed back to back; the last node is the tail sum.
    logic signed [OUT_WIDTH-1:0] r_node [NODES];
    logic signed [OUT_WIDTH-1:0] w_node [NODES];

    // Tags travelling with the tree data; bit k belongs to tree level k.
    logic [LVLS:0] r_vld;
    logic [LVLS:0] r_acc;
    logic [LVLS:0] r_last;

    // Accumulator state for the packet currently being summed.
    logic signed [OUT_WIDTH-1:0] r_accum;
    logic                        r_sat;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic                        r_in_pkt;

    // Registered result presented downstream.
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic                        r_out_sat;
    logic [CNT_WIDTH-1:0]        r_out_beats;
    logic                        r_out_valid;

    logic                        w_adv;
    logic                        w_fire;
    logic                        w_start;
    logic                        w_clamp;
    logic                        w_sat_nxt;
    logic signed [OUT_WIDTH-1:0] w_base;
    logic signed [OUT_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;

    // Everything moves only when no result is stuck waiting downstream.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = rst_n && w_adv;
    assign w_fire   = w_adv && r_vld[LVLS];

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_beats = r_out_beats;

    // Next value of every tree node: capture operands, then pairwise sums with
    // an odd leftover forwarded unchanged to the next level.
    always_comb begin
        w_node = r_node;
        for (int i = 0; i < NUM_IN; i++) begin
            w_node[i] = sext(in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]);
        end
        for (int k = 1; k <= LVLS; k++) begin
            for (int j = 0; j < lvl_cnt(k); j++) begin
                if (2*j + 1 < lvl_cnt(k-1)) begin
                    w_node[lvl_off(k) + j] = r_node[lvl_off(k-1) + 2*j]
                                           + r_node[lvl_off(k-1) + 2*j + 1];
                end else begin
                    w_node[lvl_off(k) + j] = r_node[lvl_off(k-1) + 2*j];
                end
            end
        end
    end

    // Tree data registers, frozen while the output is back-pressured.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                r_node[n] <= '0;
            end
        end else if (w_adv) begin
            r_node <= w_node;
        end
    end

    // Valid/acc/last tags shift in lockstep with the tree data.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_acc  <= '0;
            r_last <= '0;
        end else if (w_adv) begin
            r_vld  <= {r_vld[LVLS-1:0],  in_valid};
            r_acc  <= {r_acc[LVLS-1:0],  in_acc};
            r_last <= {r_last[LVLS-1:0], in_last};
        end
    end

    // Accumulator next state; a beat opens a new packet when its acc tag is 0
    // or when no packet is open (after reset or after a last beat).
    always_comb begin
        w_start   = !r_acc[LVLS] || !r_in_pkt;
        w_base    = w_start ? '0 : r_accum;
        {w_clamp, w_sum} = sat_add(w_base, r_node[TAIL]);
        w_sat_nxt = (!w_start && r_sat) || w_clamp;
        if (w_start) begin
            w_cnt_nxt = CNT_ONE;
        end else if (&r_cnt) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Accumulator, sticky clamp flag and beat counter update on each tail beat.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum  <= '0;
            r_sat    <= 1'b0;
            r_cnt    <= '0;
            r_in_pkt <= 1'b0;
        end else if (w_fire) begin
            r_accum  <= w_sum;
            r_sat    <= w_sat_nxt;
            r_cnt    <= w_cnt_nxt;
            r_in_pkt <= !r_last[LVLS];
        end
    end

    // Result register: loads on a last tail beat, otherwise drops valid once taken.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_beats <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fire && r_last[LVLS]) begin
            r_out_data  <= w_sum;
            r_out_sat   <= w_sat_nxt;
            r_out_beats <= w_cnt_nxt;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe
// Scoreboard bench: each accepted beat is folded into a packet-level model and
// every completed packet pushes its expected result; a monitor pops and compares
// whenever the DUT hands a result over.

module tb_adder_tree_pipe;

    localparam int FW  = 8;
    localparam int NI  = 9;
    localparam int OW  = 12;
    localparam int CW  = 8;
    localparam int LAT = 5;
    localparam int AMAX = 2047;
    localparam int AMIN = -2048;

    logic              fast_clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NI*FW-1:0]  in_data;
    logic              in_acc;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic signed [OW-1:0] out_data;
    logic              out_sat;
    logic [CW-1:0]     out_beats;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        int data;
        bit sat;
        int beats;
        int vcyc;
        bit lat;
    } exp_t;

    exp_t q[$];

    bit m_in_pkt;
    int m_acc;
    bit m_sat;
    int m_beats;

    adder_tree_pipe #(
        .FEATURE_WIDTH(FW),
        .NUM_IN(NI),
        .OUT_WIDTH(OW),
        .CNT_WIDTH(CW)
    ) dut (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_acc   (in_acc),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_beats(out_beats)
    );

    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [NI*FW-1:0] rep(input int v);
        logic [31:0]   w;
        logic [FW-1:0] b;
        w = v;
        b = w[FW-1:0];
        return {NI{b}};
    endfunction

    function automatic logic [NI*FW-1:0] rnd_data();
        logic [NI*FW-1:0] d;
        logic [31:0]      r;
        for (int i = 0; i < NI; i++) begin
            r = $urandom;
            d[i*FW +: FW] = r[FW-1:0];
        end
        return d;
    endfunction

    function automatic void model_reset();
        m_in_pkt = 1'b0;
        m_acc    = 0;
        m_sat    = 1'b0;
        m_beats  = 0;
        q.delete();
    endfunction

    // Packet-level behaviour: sum the operands, clamp the running total, count beats.
    function automatic void model_accept(input logic [NI*FW-1:0] d, input bit acc, input bit last);
        int s;
        logic signed [FW-1:0] op;
        exp_t e;
        s = 0;
        for (int i = 0; i < NI; i++) begin
            op = d[i*FW +: FW];
            s += int'(op);
        end
        if (!acc || !m_in_pkt) begin
            m_acc   = 0;
            m_sat   = 1'b0;
            m_beats = 0;
        end
        m_acc = m_acc + s;
        if (m_acc > AMAX) begin
            m_acc = AMAX;
            m_sat = 1'b1;
        end else if (m_acc < AMIN) begin
            m_acc = AMIN;
            m_sat = 1'b1;
        end
        if (m_beats < 255) m_beats++;
        if (last) begin
            e.data  = m_acc;
            e.sat   = m_sat;
            e.beats = m_beats;
            e.vcyc  = cyc + LAT + 1;
            e.lat   = lat_chk;
            q.push_back(e);
            m_in_pkt = 1'b0;
        end else begin
            m_in_pkt = 1'b1;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [NI*FW-1:0] d, input bit acc, input bit last);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_acc   = acc;
        in_last  = last;
        while (!done) begin
            @(negedge fast_clk);
            if (in_ready) begin
                model_accept(d, acc, last);
                done = 1'b1;
            end else if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=not_accepted required=accepted");
                done = 1'b1;
            end
            guard++;
            @(posedge fast_clk);
            #1;
        end
        in_valid = 1'b0;
        in_acc   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge fast_clk);
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge fast_clk);
            guard++;
        end
        check("pending_result", out_valid, 1);
        @(posedge fast_clk);
        #1;
    endtask

    task automatic freeze_check();
        for (int i = 0; i < 10; i++) begin
            @(negedge fast_clk);
            check("frozen_in_ready", in_ready, 0);
            check("frozen_out_valid", out_valid, 1);
        end
        @(posedge fast_clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        logic signed [OW-1:0] h_data;
        logic                 h_sat;
        logic [CW-1:0]        h_beats;
        bit                   h_hold;
        h_hold = 1'b0;
        forever begin
            @(negedge fast_clk);
            if (!rst_n) begin
                h_hold = 1'b0;
            end else begin
                if (h_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, h_data);
                    check("hold_sat", out_sat, h_sat);
                    check("hold_beats", out_beats, h_beats);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%0d required=no_output", out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_sat", out_sat, e.sat);
                        check("out_beats", out_beats, e.beats);
                        if (e.lat) check("latency_cycle", cyc, e.vcyc);
                    end
                end
                h_hold  = out_valid && !out_ready;
                h_data  = out_data;
                h_sat   = out_sat;
                h_beats = out_beats;
            end
        end
    endtask

    initial begin
        bit rnd_done;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(posedge fast_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge fast_clk);
        #1;

        // single beat of ones, latency checked
        lat_chk = 1'b1;
        send_beat(rep(1), 1'b0, 1'b1);
        drain();

        // three beats summing to zero
        send_beat(rep(-2), 1'b0, 1'b0);
        send_beat(rep(-1), 1'b1, 1'b0);
        send_beat(rep(3),  1'b1, 1'b1);
        drain();

        // positive clamp, then a fresh packet clears the flag
        for (int i = 0; i < 20; i++) begin
            send_beat(rep(127), (i != 0), (i == 19));
        end
        send_beat(rep(0), 1'b0, 1'b1);
        drain();

        // negative clamp
        for (int i = 0; i < 3; i++) begin
            send_beat(rep(-128), 1'b1, (i == 2));
        end
        drain();

        // back-to-back single-beat packets, acc=1 must still start fresh
        for (int i = 0; i < 8; i++) begin
            send_beat(rnd_data(), 1'b1, 1'b1);
        end
        drain();

        // backpressure with beats frozen inside the tree
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        send_beat(rep(5), 1'b0, 1'b1);
        send_beat(rnd_data(), 1'b0, 1'b0);
        send_beat(rnd_data(), 1'b1, 1'b0);
        send_beat(rnd_data(), 1'b1, 1'b1);
        wait_out_valid();
        fork
            send_beat(rep(-7), 1'b0, 1'b1);
            freeze_check();
        join
        drain();

        // reset in the middle of a packet
        lat_chk = 1'b1;
        send_beat(rep(1), 1'b0, 1'b0);
        send_beat(rep(1), 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_sat", out_sat, 0);
        check("mid_rst_out_beats", out_beats, 0);
        check("mid_rst_in_ready", in_ready, 0);
        model_reset();
        repeat (2) @(posedge fast_clk);
        #1;
        rst_n = 1'b1;
        send_beat(rep(1), 1'b1, 1'b1);
        drain();

        // random packets under random backpressure
        lat_chk  = 1'b0;
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        send_beat(rnd_data(), 1'($urandom_range(0, 1)), (b == len - 1));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge fast_clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
